// File: rtl/oam_arbiter_if.sv
// OAM arbiter bus bundle: CPU port, PPU scan/render ports, DMA source bus and OAM RAM port.
// The arbiter takes the slave side; the environment (CPU, PPU, memories) takes the master side.
interface oam_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_oam_sel;
    logic        cpu_dma_sel;
    logic [7:0]  cpu_a;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        scan_req;
    logic [7:0]  scan_a;
    logic        render_req;
    logic [7:0]  render_a;
    logic [15:0] dma_a;
    logic        dma_rd;
    logic [7:0]  dma_din;
    logic [7:0]  oam_a;
    logic [7:0]  oam_din;
    logic [7:0]  oam_dout;
    logic        oam_we;
    logic        oam_oe;
    logic        dma_active;
    logic [1:0]  owner;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_oam_sel, cpu_dma_sel, cpu_a, cpu_din,
        input  scan_req, scan_a, render_req, render_a, dma_din, oam_dout,
        output cpu_dout, dma_a, dma_rd, oam_a, oam_din, oam_we, oam_oe,
        output dma_active, owner
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_oam_sel, cpu_dma_sel, cpu_a, cpu_din,
        output scan_req, scan_a, render_req, render_a, dma_din, oam_dout,
        input  cpu_dout, dma_a, dma_rd, oam_a, oam_din, oam_we, oam_oe,
        input  dma_active, owner
    );
endinterface

// File: rtl/oam_arbiter.sv
// OAM arbiter: grants OAM to DMA > render > scan > CPU and runs the FF46 OAM DMA engine.
// Latency: arbitration and CPU reads are combinational; a DMA byte takes one RD plus one WR cycle.
// Backpressure: none; losing requesters are simply not served (CPU reads FF, writes dropped).
module oam_arbiter (
    input  logic         clk2,
    input  logic         nreset_video,
    oam_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RD    = 2'd2,
        WR    = 2'd3
    } dma_state_t;

    localparam logic [1:0] OWN_CPU    = 2'd0;
    localparam logic [1:0] OWN_SCAN   = 2'd1;
    localparam logic [1:0] OWN_RENDER = 2'd2;
    localparam logic [1:0] OWN_DMA    = 2'd3;
    localparam logic [7:0] IDX_LAST   = 8'h9F;
    localparam logic [7:0] OAM_LIMIT  = 8'hA0;

    dma_state_t state, state_nxt;
    logic [7:0] page, idx, idx_nxt, data;
    logic [7:0] src_page;
    logic       dma_wr_hit;
    logic       dma_own;
    logic       cpu_in_range;
    logic [1:0] owner_sel;

    assign dma_wr_hit   = bus.cpu_wr & bus.cpu_dma_sel;
    assign dma_own      = (state == RD) || (state == WR);
    assign cpu_in_range = bus.cpu_oam_sel && (bus.cpu_a < OAM_LIMIT);
    // Pages E0-FF fold onto the work-RAM echo at C0-DF.
    assign src_page     = (page >= 8'hE0) ? (page - 8'h20) : page;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (dma_wr_hit) begin
            state_nxt = START;
            idx_nxt   = 8'h00;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                START: state_nxt = RD;
                RD:    state_nxt = WR;
                WR: begin
                    if (idx < IDX_LAST) begin
                        idx_nxt   = idx + 8'h01;
                        state_nxt = RD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk2 or negedge nreset_video) begin
        if (!nreset_video) begin
            state <= IDLE;
            idx   <= 8'h00;
            page  <= 8'hFF;
            data  <= 8'h00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (dma_wr_hit) begin
                page <= bus.cpu_din;
            end
            if (state == RD) begin
                data <= bus.dma_din;
            end
        end
    end

    always_comb begin
        if (dma_own) begin
            owner_sel = OWN_DMA;
        end else if (bus.render_req) begin
            owner_sel = OWN_RENDER;
        end else if (bus.scan_req) begin
            owner_sel = OWN_SCAN;
        end else begin
            owner_sel = OWN_CPU;
        end
    end

    always_comb begin
        bus.oam_a   = 8'h00;
        bus.oam_din = 8'h00;
        bus.oam_we  = 1'b0;
        bus.oam_oe  = 1'b0;
        case (owner_sel)
            OWN_DMA: begin
                // A FF46 write landing in WR kills this byte so an aborted transfer leaves no partial write.
                if ((state == WR) && !dma_wr_hit) begin
                    bus.oam_we  = 1'b1;
                    bus.oam_a   = idx;
                    bus.oam_din = data;
                end
            end
            OWN_RENDER: begin
                bus.oam_oe = 1'b1;
                bus.oam_a  = bus.render_a;
            end
            OWN_SCAN: begin
                bus.oam_oe = 1'b1;
                bus.oam_a  = bus.scan_a;
            end
            default: begin
                if (cpu_in_range && bus.cpu_wr) begin
                    bus.oam_we  = 1'b1;
                    bus.oam_a   = bus.cpu_a;
                    bus.oam_din = bus.cpu_din;
                end else if (cpu_in_range && bus.cpu_rd) begin
                    bus.oam_oe = 1'b1;
                    bus.oam_a  = bus.cpu_a;
                end
            end
        endcase
    end

    always_comb begin
        bus.cpu_dout = 8'hFF;
        if (bus.cpu_dma_sel) begin
            bus.cpu_dout = page;
        end else if (cpu_in_range && bus.cpu_rd && (owner_sel == OWN_CPU)) begin
            bus.cpu_dout = bus.oam_dout;
        end
    end

    assign bus.owner      = owner_sel;
    assign bus.dma_active = (state != IDLE);
    assign bus.dma_rd     = (state == RD);
    assign bus.dma_a      = (state == RD) ? {src_page, idx} : 16'h0000;
endmodule

// File: doc/oam_arbiter.md
OAM_ARBITER -- requirements
Module: oam_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: clk2 (input, 1, rising-edge system clock) and nreset_video (input, 1, asynchronous active-low reset).
REQ-002 cpu_rd / cpu_wr  input  1  CPU read/write strobes, one clk2 cycle wide.
REQ-003 cpu_oam_sel  input  1  CPU address in FE00-FE9F.
REQ-004 cpu_dma_sel  input  1  CPU address is FF46.
REQ-005 cpu_a  input  8  CPU address low byte (OAM offset).
REQ-006 cpu_din  input  8  CPU write data.
REQ-007 cpu_dout  output  8  CPU read data: OAM byte or FF46 register.
REQ-008 scan_req / scan_a  input  1/8  sprite-scan (mode 2) request and OAM address.
REQ-009 render_req / render_a  input  1/8  sprite-fetch (mode 3) request and OAM address.
REQ-010 dma_a  output  16  DMA source address on the external bus.
REQ-011 dma_rd  output  1  DMA source read strobe.
REQ-012 dma_din  input  8  DMA source data, valid in the cycle dma_rd is high.
REQ-013 oam_a / oam_din  output  8/8  OAM address and write data.
REQ-014 oam_dout  input  8  OAM read data.
REQ-015 oam_we / oam_oe  output  1/1  OAM write and read enables.
REQ-016 dma_active  output  1  DMA in START or XFER.
REQ-017 owner  output  2  Current OAM owner: 0 = CPU, 1 = scan, 2 = render, 3 = DMA.

Function
REQ-018 DMA FSM states SHALL be IDLE, START, RD and WR.
REQ-019 A write with cpu_wr and cpu_dma_sel SHALL load the page register from cpu_din, clear idx to 0 and enter START in the next cycle, from any state.
REQ-020 START SHALL last exactly one cycle, then go to RD.
REQ-021 In RD, the block SHALL drive dma_rd=1 and dma_a={src_page,idx}, and latch dma_din into a data register at the clock edge.
REQ-022 src_page SHALL equal the page register when page is below E0; for pages E0-FF it SHALL equal page-0x20.
REQ-023 In WR, the block SHALL drive oam_we=1, oam_a=idx and oam_din=latched data.
REQ-024 At the end of WR, if idx is below 0x9F, the block SHALL increment idx and return to RD; if idx is 0x9F, it SHALL go to IDLE.
REQ-025 A transfer SHALL take 160 RD+WR pairs (320 cycles).
REQ-026 A FF46 write arriving in RD or WR SHALL abort the current transfer with no partial write, and restart per REQ-019.
REQ-027 A CPU read of FF46 SHALL return the page register on cpu_dout in the same cycle.
REQ-028 dma_active SHALL be 1 in START, RD and WR.
REQ-029 Owner priority SHALL be: DMA (RD/WR only) > render_req > scan_req > CPU. Owner is combinational from the current state and requests.
REQ-030 In START, owner SHALL be arbitrated without DMA.
REQ-031 When owner is scan or render, the block SHALL drive oam_oe=1 and oam_a=scan_a or render_a.
REQ-032 In DMA RD, oam_oe and oam_we SHALL be 0.
REQ-033 When owner is CPU and cpu_oam_sel is set: cpu_rd SHALL give oam_oe=1, oam_a=cpu_a and cpu_dout=oam_dout.
REQ-034 When owner is CPU and cpu_oam_sel is set: cpu_wr SHALL give oam_we=1, oam_a=cpu_a and oam_din=cpu_din.
REQ-035 A CPU OAM access while owner is not CPU SHALL be blocked: reads return FF, writes are dropped, and there is no OAM strobe.
REQ-036 cpu_oam_sel with cpu_a at or above 0xA0 SHALL return FF and ignore writes.
REQ-037 Simultaneous scan_req and render_req SHALL grant render.
REQ-038 When no owner accesses OAM, oam_a SHALL be 0 and oam_we/oam_oe SHALL be 0.
REQ-039 The block SHALL never drive oam_we and oam_oe high in the same cycle.

Reset
REQ-040 nreset_video low SHALL asynchronously force FSM=IDLE, idx=0, page=0xFF and data register=0.
REQ-041 While reset is held, dma_active, dma_rd, oam_we and oam_oe SHALL be 0, and owner SHALL follow REQ-029 with DMA idle.
REQ-042 Reset in the middle of a transfer SHALL abort it immediately; no further OAM writes occur after reset deasserts.

Verification
REQ-043 Basic transfer: FF46←0xC1 written at cycle N -> START at N+1; RD at N+2 with dma_a=C100; first oam_we at N+3 with oam_a=00; last oam_we at N+321 with oam_a=9F; dma_active=0 at N+322; OAM[i]=src[C100+i].
REQ-044 Echo page: FF46←0xE3 -> dma_a runs C300-C39F.
REQ-045 Restart: FF46←0x80, then FF46←0x90 when idx=0x40 -> no write at idx 0x40 from the first transfer; next RD at dma_a=9000; 160 writes from page 90.
REQ-046 Contention: scan_req=1 plus CPU read of FE10 -> cpu_dout=FF, owner=1.
REQ-047 Contention: render_req and scan_req both 1 -> owner=2, oam_a=render_a.
REQ-048 Contention: DMA in RD/WR plus render_req=1 -> owner=3.
REQ-049 Reset mid-DMA: pull nreset_video low at idx=0x20 -> dma_active=0 in the same cycle; FF46 reads FF after release; no oam_we until the next FF46 write.
REQ-050 Idle CPU: owner=0; CPU write FE05←5A then read FE05 -> oam_we with oam_a=05, then cpu_dout=5A; FEA0 read -> FF.
